// File: rtl/score_ctrl.sv
// score_ctrl: game-flow controller for the dino score counter.
//   Synchronises the raw start/pause buttons and the collision level.
//   Runs the IDLE/RUN/PAUSE/OVER state machine and emits one-cycle
//   game_start / game_over / game_tick pulses. Tracks the session high score.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   btn_start/btn_pause raw asynchronous buttons (rising edge = press)
//   collision           raw asynchronous collision level
//   score_in            live score from the counter (unsigned)
//   game_start          pulse: clear counter and start counting
//   game_over           pulse: freeze counter
//   game_tick           pulse every TICK_DIV clocks while in RUN
//   state_out           0=IDLE 1=RUN 2=PAUSE 3=OVER
//   high_score          best final score since reset
//   new_high            level: last finished game set a new high score
module score_ctrl #(
  parameter int TICK_DIV  = 166667,
  parameter int SCORE_W   = 16,
  parameter int SCORE_LAT = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_start,
  input  logic               btn_pause,
  input  logic               collision,
  input  logic [SCORE_W-1:0] score_in,
  output logic               game_start,
  output logic               game_over,
  output logic               game_tick,
  output logic [1:0]         state_out,
  output logic [SCORE_W-1:0] high_score,
  output logic               new_high
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int LAT_W = $clog2(SCORE_LAT + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(SCORE_LAT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    OVER  = 2'd3
  } state_t;

  // Input stage: bit0/bit1 form the 2-flop synchroniser, bit2 is the
  // delayed copy used for rising-edge detection.
  logic [2:0] start_sync_q;
  logic [2:0] pause_sync_q;
  logic [1:0] coll_sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      start_sync_q <= '0;
      pause_sync_q <= '0;
      coll_sync_q  <= '0;
    end else begin
      start_sync_q <= {start_sync_q[1:0], btn_start};
      pause_sync_q <= {pause_sync_q[1:0], btn_pause};
      coll_sync_q  <= {coll_sync_q[0], collision};
    end
  end

  logic start_edge;
  logic pause_edge;
  logic coll_sync;

  assign start_edge = start_sync_q[1] & ~start_sync_q[2];
  assign pause_edge = pause_sync_q[1] & ~pause_sync_q[2];
  assign coll_sync  = coll_sync_q[1];

  // Control stage: FSM, tick divider and high-score latency tracker.
  state_t             state_q;
  logic               game_start_q;
  logic               game_over_q;
  logic               game_tick_q;
  logic [DIV_W-1:0]   div_q;
  logic [SCORE_W-1:0] high_q;
  logic               new_high_q;
  logic [LAT_W-1:0]   lat_cnt_q;
  logic               lat_pend_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      game_start_q <= 1'b0;
      game_over_q  <= 1'b0;
      game_tick_q  <= 1'b0;
      div_q        <= '0;
      high_q       <= '0;
      new_high_q   <= 1'b0;
      lat_cnt_q    <= '0;
      lat_pend_q   <= 1'b0;
    end else begin
      game_start_q <= 1'b0;
      game_over_q  <= 1'b0;
      game_tick_q  <= 1'b0;

      // Collision outranks pause, pause outranks start.
      case (state_q)
        IDLE, OVER: begin
          if (start_edge) begin
            state_q      <= RUN;
            game_start_q <= 1'b1;
            div_q        <= '0;
            new_high_q   <= 1'b0;
          end
        end
        RUN: begin
          if (coll_sync) begin
            state_q     <= OVER;
            game_over_q <= 1'b1;
          end else if (pause_edge) begin
            state_q <= PAUSE;
          end else if (div_q == DIV_LAST) begin
            div_q       <= '0;
            game_tick_q <= 1'b1;
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end
        PAUSE: begin
          if (coll_sync) begin
            state_q     <= OVER;
            game_over_q <= 1'b1;
          end else if (pause_edge) begin
            state_q <= RUN;
          end
        end
        default: state_q <= IDLE;
      endcase

      // lat_cnt_q counts cycles since the game_over pulse; the compare
      // fires when score_in is guaranteed to hold the final score. It runs
      // independently of the FSM so a quick restart does not cancel it.
      if (lat_pend_q) begin
        if (lat_cnt_q == LAT_LAST) begin
          lat_pend_q <= 1'b0;
          if (score_in > high_q) begin
            high_q     <= score_in;
            new_high_q <= 1'b1;
          end
        end else begin
          lat_cnt_q <= lat_cnt_q + LAT_W'(1);
        end
      end
      if (game_over_q) begin
        lat_pend_q <= 1'b1;
        lat_cnt_q  <= LAT_W'(1);
      end
    end
  end

  assign game_start = game_start_q;
  assign game_over  = game_over_q;
  assign game_tick  = game_tick_q;
  assign state_out  = state_q;
  assign high_score = high_q;
  assign new_high   = new_high_q;

endmodule
